// File: rtl/pwm_capture_ctrl.sv
// rtl/pwm_capture_ctrl.sv - PWM high-time / period capture FSM driving an external 8-bit counter
// Results are held behind a valid/ready handshake; results that complete while one is still unconsumed are dropped.
module pwm_capture_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       pwm_in,
    input  logic [7:0] counter_value,
    output logic       cnt_reset,
    output logic       cnt_enable,
    output logic [7:0] high_width,
    output logic [7:0] period,
    output logic       meas_valid,
    input  logic       meas_ready,
    output logic       meas_drop,
    output logic       cnt_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;
    logic [7:0]             r_hw_tmp;
    logic [7:0]             r_high_width;
    logic [7:0]             r_period;
    logic                   r_meas_valid;
    logic                   r_meas_drop;
    logic                   r_cnt_overflow;

    logic w_pwm_s;
    logic w_rise;
    logic w_fall;
    logic w_sat;
    logic w_done;

    assign w_pwm_s = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_pwm_s & ~r_pwm_d;
    assign w_fall  = ~w_pwm_s & r_pwm_d;
    assign w_sat   = (counter_value == 8'hFF);

    // A saturated counter means the period is out of range, so it beats the closing rise.
    assign w_done  = run && (r_state == ST_LOW) && w_rise && !w_sat;

    assign cnt_reset  = reset || (r_state == ST_IDLE) || (r_state == ST_ARM)
                        || ((r_state == ST_LOW) && w_rise);
    assign cnt_enable = !reset && ((r_state == ST_HIGH) || (r_state == ST_LOW));

    assign high_width   = r_high_width;
    assign period       = r_period;
    assign meas_valid   = r_meas_valid;
    assign meas_drop    = r_meas_drop;
    assign cnt_overflow = r_cnt_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_sync         <= '0;
            r_pwm_d        <= 1'b0;
            r_hw_tmp       <= 8'd0;
            r_high_width   <= 8'd0;
            r_period       <= 8'd0;
            r_meas_valid   <= 1'b0;
            r_meas_drop    <= 1'b0;
            r_cnt_overflow <= 1'b0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d        <= w_pwm_s;
            r_meas_drop    <= 1'b0;
            r_cnt_overflow <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end else if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end else if (w_sat) begin
                        r_cnt_overflow <= 1'b1;
                        r_state        <= ST_ARM;
                    end else if (w_fall) begin
                        r_hw_tmp <= counter_value + 8'd1;
                        r_state  <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end else if (w_sat) begin
                        r_cnt_overflow <= 1'b1;
                        r_state        <= ST_ARM;
                    end else if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A transfer in the same cycle frees the holding registers for the new result.
            if (w_done) begin
                if (!r_meas_valid || meas_ready) begin
                    r_high_width <= r_hw_tmp;
                    r_period     <= counter_value + 8'd1;
                    r_meas_valid <= 1'b1;
                end else begin
                    r_meas_drop <= 1'b1;
                end
            end else if (r_meas_valid && meas_ready) begin
                r_meas_valid <= 1'b0;
            end
        end
    end

endmodule
